// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer ALU with valid/ready handshakes on both sides.
// Latency: 1 cycle for every op; shifts by shamt>0 take 1+shamt cycles unless ALU_FAST_SHIFT_EN.
// Backpressure: result and flags are held in DONE while out_ready is low; in_ready is low in SHIFT.
//
// Optional feature macro: ALU_FAST_SHIFT_EN (barrel shifter, SHIFT state unreachable).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        request handshake (alu_op, op_a, op_b captured on transfer)
//   alu_op[3:0], op_a, op_b    operation code and operands
//   out_valid / out_ready      result handshake
//   result, flag_z/n/c/v       result and zero/negative/carry/overflow flags
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]            sop_q, sop_d;
  logic                  z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic [SHAMT_W-1:0]    shamt;
  logic                  is_shift;
  logic                  go_shift;
  logic                  accept;
  logic [DATA_WIDTH:0]   add_w;
  logic [DATA_WIDTH:0]   sub_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_v;
  logic [DATA_WIDTH-1:0] step_val;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = is_shift && (shamt != '0);
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  assign result = res_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

  // Subtraction as a + ~b + 1, so the carry-out is the unsigned "no borrow" (a >= b).
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_WIDTH+1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = add_w[DATA_WIDTH-1:0];
        alu_c   = add_w[DATA_WIDTH];
        alu_v   = (op_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                  (add_w[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[DATA_WIDTH-1:0];
        alu_c   = sub_w[DATA_WIDTH];
        alu_v   = (op_a[DATA_WIDTH-1] != op_b[DATA_WIDTH-1]) &&
                  (sub_w[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
      // Only reached with shamt == 0; non-zero amounts take the iterative path.
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter; sop_q remembers which shift was accepted.
  always_comb begin
    case (sop_q)
      OP_SLL:  step_val = {res_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  step_val = {res_q[DATA_WIDTH-1], res_q[DATA_WIDTH-1:1]};
      default: step_val = {1'b0, res_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        res_d = step_val;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
          z_d     = (step_val == '0);
          n_d     = step_val[DATA_WIDTH-1];
          c_d     = 1'b0;
          v_d     = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // in_ready is low in SHIFT, so accept only fires from IDLE or a draining DONE.
    if (accept) begin
      if (go_shift) begin
        state_d = SHIFT;
        res_d   = op_a;
        cnt_d   = shamt;
        sop_d   = alu_op;
        z_d     = 1'b0;
        n_d     = 1'b0;
        c_d     = 1'b0;
        v_d     = 1'b0;
      end else begin
        state_d = DONE;
        res_d   = alu_res;
        z_d     = (alu_res == '0);
        n_d     = alu_res[DATA_WIDTH-1];
        c_d     = alu_c;
        v_d     = alu_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand/result width.
REQ-002 Parameter: SHAMT_W, 5, shift-amount width taken from op_b[SHAMT_W-1:0].
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 alu_op  input  4  operation code (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, per constant_def.vh).
REQ-008 op_a, op_b  input  DATA_WIDTH each  operands.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  DATA_WIDTH  operation result.
REQ-012 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/no-borrow, signed overflow.

Function
REQ-013 Transfer in occurs when in_valid and in_ready are high on a rising edge; transfer out when out_valid and out_ready are high.
REQ-014 State machine SHALL have states IDLE, SHIFT, DONE; in_ready high in IDLE, and in DONE only while out_ready is high; low in SHIFT.
REQ-015 Accepting in IDLE/DONE: non-shift op or shamt=0 -> DONE next cycle; shift op with shamt>0 -> SHIFT (iterative build).
REQ-016 SHIFT SHALL shift the working register one bit per cycle, decrementing a counter; when counter reaches 0 -> DONE; latency from accept to out_valid = 1 + shamt cycles.
REQ-017 DONE holds result and flags stable while out_ready is low; out_ready high without new accept -> IDLE; out_ready high with accept -> follows REQ-015 (back-to-back, no bubble).
REQ-018 ADD/SUB results modulo 2^DATA_WIDTH; SLT signed compare, SLTU unsigned, result 1 or 0 zero-extended.
REQ-019 SRA SHALL replicate op_a MSB; SRL/SLL shift in zeros.
REQ-020 Codes 10-15 SHALL produce result 0, flag_c=0, flag_v=0.
REQ-021 flag_z = (result==0); flag_n = result MSB; flag_c = carry-out (ADD) or op_a>=op_b unsigned (SUB), else 0; flag_v = signed overflow (ADD/SUB), else 0.
REQ-022 Operands, alu_op, and shamt SHALL be captured at accept; later input changes SHALL NOT affect an in-flight operation.
REQ-023 in_valid during SHIFT SHALL be ignored (no capture, no state change).

Reset
REQ-024 While rst_n low at a rising edge: state=IDLE, out_valid=0, result=0, all flags=0, shift counter=0.
REQ-025 Reset mid-SHIFT or in DONE SHALL discard the operation; no out_valid asserted for it.
REQ-026 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-027 Macro ALU_FAST_SHIFT_EN defined: shifts computed by barrel shifter, all ops go directly to DONE, latency 1 cycle, SHIFT state unreachable.
REQ-028 Macro undefined: iterative shift per REQ-016; results identical to defined case for every input.

Verification
REQ-029 ADD op_a=0x7FFFFFFF, op_b=1, out_ready=1 -> out_valid one cycle later, result=0x80000000, flag_v=1, flag_n=1, flag_c=0, flag_z=0.
REQ-030 SUB op_a=5, op_b=5 -> result=0, flag_z=1, flag_c=1; SLT op_a=0xFFFFFFFF, op_b=1 -> result=1; SLTU same operands -> result=0.
REQ-031 SRA op_a=0x80000000, op_b=4 (iterative) -> out_valid 5 cycles after accept, result=0xF8000000, in_ready low 4 cycles; with ALU_FAST_SHIFT_EN -> 1 cycle.
REQ-032 Result pending, out_ready held low 3 cycles -> result/flags stable, in_ready low; then out_ready=1 with in_valid=1 AND 0xF0F0, 0x0FF0 -> next cycle result=0x00F0, no idle bubble.
REQ-033 SLL op_a=1, op_b=31 issued, rst_n pulsed low at cycle 10 -> out_valid never asserted for it, outputs 0, in_ready=1 after release.
REQ-034 alu_op=12, any operands -> result=0, flag_z=1, flag_c=0, flag_v=0.
